cla_adder32: RTL and testbench
==============================

Name: cla_adder32

Overview:
Unsigned 32-bit carry-lookahead adder producing a 33-bit sum (carry-out in the MSB). The sum path is purely combinational, so a result is available within the same evaluation step as the operands. A registered copy of the sum is also provided for pipelined consumers, clocked by the single block clock and cleared by the asynchronous active-low reset. The block is a drop-in replacement for the ripple-carry adder in the datapath.

Parameters:
WIDTH, 32, operand width; must be a multiple of GROUP.
GROUP, 4, bits per lookahead group.

Ports:
clk  input  1  block clock; rising edge samples the combinational sum into z_q.
rst_n  input  1  asynchronous, active-low reset; clears z_q only.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
z  output  WIDTH+1  combinational sum a+b; z[WIDTH] is carry-out.
z_q  output  WIDTH+1  registered sum; z at the previous rising clk edge.

Behaviour:
- One clock (clk) and one reset (rst_n). Reset is asynchronous and active-low.
- z = zero-extended a + zero-extended b, exact over WIDTH+1 bits. There is no carry-in, and no overflow is possible.
- z is combinational, with 0-cycle latency.
  - z must settle in the same delta/timestep as any change on a or b.
  - z contains no state and is independent of clk and rst_n, including during reset.
- Structure: carry-lookahead, not ripple.
  - Bit level: generate g_i = a_i & b_i, propagate p_i = a_i ^ b_i.
  - Group level (GROUP bits): group generate G = g3 | p3g2 | p3p2g1 | p3p2p1g0 and group propagate P = p3p2p1p0.
  - Inter-group carries come from a second lookahead level over the groups. For WIDTH=32 this is 8 groups, computed as two 4-group lookahead blocks chained by the block carry.
  - Bit carries c_{i+1} = g_i | p_i c_i within a group, computed in lookahead form from the group carry-in. Carry into bit 0 is 0.
  - Sum bit s_i = p_i ^ c_i. z[WIDTH] = carry out of the top group.
- z_q behaviour:
  - rst_n low: z_q is forced to 0 immediately, without waiting for a clock edge, and stays 0 while rst_n is low.
  - Rising clk with rst_n high: z_q <= z.
  - Reset release: the first rising edge after rst_n goes high loads z normally.
- No X-propagation masking is required. Any X on an a or b bit may propagate into z.
- Boundary conditions:
  - All-ones + 1 carries through every group to z[32]=1 with the lower bits all zero.
  - Carry must propagate correctly across group boundaries, including bits 3→4, 15→16 and 31→32.

Test Plan:
- a=0, b=0 -> z=33'h0_0000_0000 immediately; after one clk edge, z_q=0.
- a=32'hFFFF_FFFF, b=32'h0000_0001 -> z=33'h1_0000_0000 (full carry chain through all groups).
- a=32'hFFFF_FFFF, b=32'hFFFF_FFFF -> z=33'h1_FFFF_FFFE. Then a=32'h0000_FFFF, b=32'h0000_0001 -> z=33'h0_0001_0000 (cross-block carry at bit 16).
- a=32'h8000_0000, b=32'h8000_0000 -> z=33'h1_0000_0000. Then a=32'h1234_5678, b=32'h0FED_CBA8 -> z=33'h0_2222_2220.
- 20000 random a/b pairs applied with a 1-time-unit settle each -> z == a+b (33-bit) every time, with no clock required.
- Reset scenario:
  - With z_q holding 33'h1_0000_0000, assert rst_n=0 mid-cycle -> z_q=0 immediately while z still tracks a+b.
  - Release rst_n; the next rising clk edge loads z_q=z.

Source files
------------

// File: rtl/cla_adder32.sv
// Unsigned two-level carry-lookahead adder with a combinational sum and a registered copy.
// Groups of GROUP bits feed 4-group lookahead blocks that are chained by the block carry.
module cla_adder32 #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   z,
  output logic [WIDTH:0]   z_q
);

  localparam int NGRP = WIDTH / GROUP;
  localparam int BLK  = 4;
  localparam int NBLK = (NGRP + BLK - 1) / BLK;
  localparam int LA_W = (GROUP > BLK) ? GROUP : BLK;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] c;
  logic [NGRP-1:0]  grp_g;
  logic [NGRP-1:0]  grp_p;
  logic [NGRP-1:0]  grp_cin;
  logic [NBLK:0]    blk_c;

  // Carry into position n in sum-of-products form:
  // OR over k<n of gen[k] & prop[k+1..n-1], plus cin & prop[0..n-1].
  function automatic logic la_carry(
    input logic [LA_W-1:0] gen,
    input logic [LA_W-1:0] prop,
    input logic            cin,
    input int              n
  );
    logic acc;
    logic term;
    acc = 1'b0;
    for (int k = 0; k < LA_W; k++) begin
      if (k < n) begin
        term = gen[k];
        for (int m = 0; m < LA_W; m++) begin
          if (m > k && m < n) term = term & prop[m];
        end
        acc = acc | term;
      end
    end
    term = cin;
    for (int m = 0; m < LA_W; m++) begin
      if (m < n) term = term & prop[m];
    end
    return acc | term;
  endfunction

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin : grp_level
    logic [LA_W-1:0] gv;
    logic [LA_W-1:0] pv;
    grp_g = '0;
    grp_p = '0;
    for (int gi = 0; gi < NGRP; gi++) begin
      gv = '0;
      pv = '0;
      for (int j = 0; j < GROUP; j++) begin
        gv[j] = g[gi*GROUP + j];
        pv[j] = p[gi*GROUP + j];
      end
      grp_g[gi] = la_carry(gv, pv, 1'b0, GROUP);
      grp_p[gi] = &p[gi*GROUP +: GROUP];
    end
  end

  // Second level: each block of up to four groups resolves its group carries
  // in lookahead form from the block carry-in; blocks chain through blk_c.
  always_comb begin : blk_level
    logic [LA_W-1:0] gv;
    logic [LA_W-1:0] pv;
    int              n;
    grp_cin  = '0;
    blk_c    = '0;
    blk_c[0] = 1'b0;
    for (int bi = 0; bi < NBLK; bi++) begin
      gv = '0;
      pv = '0;
      n  = 0;
      for (int j = 0; j < BLK; j++) begin
        if (bi*BLK + j < NGRP) begin
          gv[j] = grp_g[bi*BLK + j];
          pv[j] = grp_p[bi*BLK + j];
          n     = j + 1;
        end
      end
      for (int j = 0; j < BLK; j++) begin
        if (bi*BLK + j < NGRP) grp_cin[bi*BLK + j] = la_carry(gv, pv, blk_c[bi], j);
      end
      blk_c[bi+1] = la_carry(gv, pv, blk_c[bi], n);
    end
  end

  always_comb begin : bit_level
    logic [LA_W-1:0] gv;
    logic [LA_W-1:0] pv;
    c = '0;
    for (int gi = 0; gi < NGRP; gi++) begin
      gv = '0;
      pv = '0;
      for (int j = 0; j < GROUP; j++) begin
        gv[j] = g[gi*GROUP + j];
        pv[j] = p[gi*GROUP + j];
      end
      for (int j = 0; j < GROUP; j++) begin
        c[gi*GROUP + j] = la_carry(gv, pv, grp_cin[gi], j);
      end
    end
  end

  assign z[WIDTH-1:0] = p ^ c;
  assign z[WIDTH]     = blk_c[NBLK];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= '0;
    else        z_q <= z;
  end

endmodule

// File: tb/tb_cla_adder32.sv
// Self-checking bench for cla_adder32: directed carry-chain cases, random sums
// against plain 33-bit arithmetic, and asynchronous reset of the registered sum.
module tb_cla_adder32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [32:0] z;
  logic [32:0] z_q;

  int n_checks = 0;
  int n_fail   = 0;

  cla_adder32 #(.WIDTH(32), .GROUP(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .z     (z),
    .z_q   (z_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] ref_sum(input logic [31:0] x, input logic [31:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] va;
    logic [31:0] vb;
    logic [32:0] vz;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 33'h1_0000_0000};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE};
    vecs[2] = '{32'h0000_FFFF, 32'h0000_0001, 33'h0_0001_0000};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 33'h1_0000_0000};
    vecs[4] = '{32'h1234_5678, 32'h0FED_CBA8, 33'h0_2222_2220};
    vecs[5] = '{32'h0000_000F, 32'h0000_0001, 33'h0_0000_0010};

    rst_n = 1'b0;
    a = 32'h0;
    b = 32'h0;
    #1;
    chk("zero_z", z, 33'h0);
    chk("reset_zq", z_q, 33'h0);

    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("zero_zq", z_q, 33'h0);

    foreach (vecs[i]) begin
      a = vecs[i].va;
      b = vecs[i].vb;
      #1;
      chk($sformatf("dir%0d", i), z, vecs[i].vz);
      chk($sformatf("dir%0d_ref", i), z, ref_sum(a, b));
    end

    for (int i = 0; i < 20000; i++) begin
      a = $urandom;
      b = $urandom;
      #1;
      chk("rand", z, ref_sum(a, b));
    end

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      a = $urandom;
      b = $urandom;
      @(posedge clk); #1;
      chk("rand_zq", z_q, ref_sum(a, b));
    end

    @(negedge clk);
    a = 32'hFFFF_FFFF;
    b = 32'h0000_0001;
    @(posedge clk); #1;
    chk("pre_reset_zq", z_q, 33'h1_0000_0000);

    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_zq", z_q, 33'h0);
    chk("reset_z", z, 33'h1_0000_0000);
    a = 32'h1234_5678;
    b = 32'h0FED_CBA8;
    #1;
    chk("reset_z_track", z, 33'h0_2222_2220);
    @(posedge clk); #1;
    chk("reset_hold_zq", z_q, 33'h0);

    @(negedge clk);
    rst_n = 1'b1;
    a = 32'hA5A5_A5A5;
    b = 32'h5A5A_5A5B;
    #1;
    chk("release_zq", z_q, 33'h0);
    @(posedge clk); #1;
    chk("first_load_zq", z_q, 33'h1_0000_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
